// File: rtl/store_buf_pkg.sv
// Shared types and sizing for the posted-write store buffer.
package store_buf_pkg;

    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_WR,
        SB_RD
    } sb_state_t;

    typedef struct packed {
        logic [SB_AW-3:0] waddr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Circular store queue with head/tail pointers and occupancy count.
// The youngest-match lookup port exists only when STORE_BUF_FWD_EN is defined.
module store_buf_fifo
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [SB_AW-3:0] push_waddr,
    input  logic [SB_DW-1:0] push_data,
    output logic [SB_AW-3:0] peek_waddr,
    output logic [SB_DW-1:0] peek_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
`ifdef STORE_BUF_FWD_EN
    ,
    input  logic [SB_AW-3:0] match_waddr,
    output logic             match_hit,
    output logic [SB_DW-1:0] match_data
`endif
);

    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  peek_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count alone defines which slots are valid.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= '{waddr: push_waddr, data: push_data};
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // When the head retires this edge, the next transaction comes from the following slot.
    assign peek_idx   = pop ? head + PTR_W'(1) : head;
    assign peek_waddr = entries[peek_idx].waddr;
    assign peek_data  = entries[peek_idx].data;

`ifdef STORE_BUF_FWD_EN
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        idx        = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (entries[idx].waddr == match_waddr)) begin
                match_hit  = 1'b1;
                match_data = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and a req/ready data memory.
// Define STORE_BUF_FWD_EN to let loads forward from queued stores and bypass them on a miss.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_state_t       state, state_nxt;
    logic            mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;

    logic [AW-3:0]   peek_waddr;
    logic [DW-1:0]   peek_data;
    logic [PTR_W:0]  count;
    logic            full, empty;

    logic            pop, push, rd_done, load_req, load_done, load_elig;
    logic            has_more, select;
    logic            unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_addr[1:0];

    // A store and a load together is illegal; the store takes precedence.
    assign load_req = cpu_re & ~cpu_we;
    assign pop      = (state == SB_WR) & mem_ready;
    assign rd_done  = (state == SB_RD) & mem_ready;
    assign push     = cpu_we & (~full | pop);
    assign has_more = pop ? (count > (PTR_W+1)'(1)) : ~empty;
    assign select   = (state == SB_IDLE) | pop | rd_done;

`ifdef STORE_BUF_FWD_EN
    logic          match_hit;
    logic [DW-1:0] match_data;
    logic          fwd_hit;

    assign fwd_hit   = load_req & match_hit;
    assign load_done = fwd_hit | rd_done;
    assign load_elig = load_req & ~load_done;
    assign cpu_rdata = fwd_hit ? match_data : mem_rdata;
`else
    // Without forwarding a load waits for every older store to reach memory.
    assign load_done = rd_done;
    assign load_elig = load_req & ~rd_done & ~has_more;
    assign cpu_rdata = mem_rdata;
`endif

    assign cpu_stall = ~reset & ((cpu_we & full & ~pop) | (load_req & ~load_done));

    store_buf_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_waddr (cpu_addr[AW-1:2]),
        .push_data  (cpu_wdata),
        .peek_waddr (peek_waddr),
        .peek_data  (peek_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef STORE_BUF_FWD_EN
        ,
        .match_waddr (cpu_addr[AW-1:2]),
        .match_hit   (match_hit),
        .match_data  (match_data)
`endif
    );

    // Next transaction is chosen only when the bus is free or finishing this edge.
    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if (select) begin
            if (load_elig) begin
                state_nxt    = SB_RD;
                mem_req_nxt  = 1'b1;
                mem_we_nxt   = 1'b0;
                mem_addr_nxt = {cpu_addr[AW-1:2], 2'b00};
            end else if (has_more) begin
                state_nxt     = SB_WR;
                mem_req_nxt   = 1'b1;
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = {peek_waddr, 2'b00};
                mem_wdata_nxt = peek_data;
            end else begin
                state_nxt   = SB_IDLE;
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    no_we_and_re: assert property (@(posedge clk) disable iff (reset) !(cpu_we && cpu_re));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, corner sequences and a
// randomized run checked against a program-order memory model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          reps;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_stall;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic        stall_seen = 1'b0;
    logic        last_stall = 1'b0;
    logic [31:0] dmem   [64];
    logic [31:0] golden [64];
    wr_t         exp_q  [$];
    vec_t        vecs   [11];

    // Memory model: data visible combinationally at the requested word.
    assign mem_rdata = dmem[mem_addr[7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata);
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // One clock: model bookkeeping before the edge, protocol checks after it.
    task automatic cycle();
        logic        wr_fire = 1'b0;
        logic        hold    = 1'b0;
        logic [31:0] sa = '0, sd = '0;
        logic        swe = 1'b0;
        wr_t         e;
        @(negedge clk);
        if (!reset) begin
            wr_fire    = mem_req & mem_ready & mem_we;
            last_stall = cpu_stall;
            if (cpu_stall) stall_seen = 1'b1;
            if (mem_req & mem_ready & ~mem_we) rd_count++;
            if (cpu_re && !cpu_we && !cpu_stall)
                check("load_data", cpu_rdata, golden[cpu_addr[7:2]]);
            if (wr_fire) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h, expected no write", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
            end
            if (cpu_we && !cpu_stall) begin
                e.addr = {cpu_addr[31:2], 2'b00};
                e.data = cpu_wdata;
                exp_q.push_back(e);
                golden[cpu_addr[7:2]] = cpu_wdata;
            end
            hold = mem_req & ~mem_ready;
            sa   = mem_addr;
            sd   = mem_wdata;
            swe  = mem_we;
        end
        @(posedge clk);
        #1;
        if (wr_fire) dmem[sa[7:2]] = sd;
        if (hold && !reset) begin
            check("hold_req", mem_req, 1);
            check("hold_we", mem_we, swe);
            check("hold_addr", mem_addr, sa);
            check("hold_wdata", mem_wdata, sd);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) golden[i] = dmem[i];
        last_stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        logic got;
        for (int i = 0; i < 64; i++) dmem[i] = 32'hA5A5_0000 + 32'(i);

        // Reset state
        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_count", 32'(dut.u_fifo.count), 0);

        // Single store with memory always ready
        mem_ready  = 1'b1;
        stall_seen = 1'b0;
        drive(1, 0, 32'h54, 32'd71);
        cycle();
        drive(0, 0, 0, 0);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
        check("t1_req_seen", got, 1);
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 32'h54);
        check("t1_wdata", mem_wdata, 32'd71);
        cycle();
        check("t1_count_empty", 32'(dut.u_fifo.count), 0);
        check("t1_req_drop", mem_req, 0);
        check("t1_no_stall", stall_seen, 0);

        // Fill to full against a stalled memory; the fifth store rides the first pop.
        do_reset();
        vecs[0]  = '{1,  1, 32'h40, 32'd1, 0, 0, 0, 32'h0};
        vecs[1]  = '{1,  1, 32'h44, 32'd2, 0, 0, 0, 32'h0};
        vecs[2]  = '{1,  1, 32'h48, 32'd3, 0, 0, 1, 32'h40};
        vecs[3]  = '{1,  1, 32'h4C, 32'd4, 0, 0, 1, 32'h40};
        vecs[4]  = '{16, 1, 32'h50, 32'd5, 0, 1, 1, 32'h40};
        vecs[5]  = '{1,  1, 32'h50, 32'd5, 1, 0, 1, 32'h40};
        vecs[6]  = '{1,  0, 32'h0,  32'd0, 0, 0, 1, 32'h44};
        vecs[7]  = '{1,  0, 32'h0,  32'd0, 1, 0, 1, 32'h44};
        vecs[8]  = '{1,  0, 32'h0,  32'd0, 1, 0, 1, 32'h48};
        vecs[9]  = '{1,  0, 32'h0,  32'd0, 1, 0, 1, 32'h4C};
        vecs[10] = '{1,  0, 32'h0,  32'd0, 1, 0, 1, 32'h50};
        for (int v = 0; v < 11; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                drive(vecs[v].we, 0, vecs[v].addr, vecs[v].wdata);
                mem_ready = vecs[v].ready;
                #1;
                check($sformatf("vec%0d_stall", v), cpu_stall, vecs[v].exp_stall);
                check($sformatf("vec%0d_req", v), mem_req, vecs[v].exp_req);
                if (vecs[v].exp_req) check($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
                cycle();
            end
        end
        check("fill_drained", 32'(exp_q.size()), 0);

`ifdef STORE_BUF_FWD_EN
        // Forward hit: youngest of two same-address stores, no memory read.
        do_reset();
        w0 = rd_count;
        drive(1, 0, 32'h60, 32'd7); cycle();
        drive(1, 0, 32'h60, 32'd9); cycle();
        drive(0, 1, 32'h60, 32'd0);
        #1;
        check("fwd_stall", cpu_stall, 0);
        check("fwd_rdata", cpu_rdata, 32'd9);
        cycle();
        drive(0, 0, 0, 0);
        #1;
        check("fwd_wr_inflight", mem_we, 1);
        check("fwd_no_rd", 32'(rd_count - w0), 0);

        // Forward miss: read goes after the in-flight write, ahead of the queued one.
        do_reset();
        dmem[32]   = 32'h1234;
        golden[32] = 32'h1234;
        drive(1, 0, 32'h10, 32'hA); cycle();
        drive(1, 0, 32'h14, 32'hB); cycle();
        drive(0, 1, 32'h80, 32'd0);
        #1;
        check("miss_stall0", cpu_stall, 1);
        check("miss_wr_addr", mem_addr, 32'h10);
        cycle();
        mem_ready = 1'b1;
        #1;
        check("miss_stall1", cpu_stall, 1);
        cycle();
        mem_ready = 1'b0;
        #1;
        check("miss_rd_req", mem_req, 1);
        check("miss_rd_we", mem_we, 0);
        check("miss_rd_addr", mem_addr, 32'h80);
        check("miss_stall2", cpu_stall, 1);
        cycle();
        mem_ready = 1'b1;
        #1;
        check("miss_done_stall", cpu_stall, 0);
        check("miss_rdata", cpu_rdata, 32'h1234);
        cycle();
        drive(0, 0, 0, 0);
        mem_ready = 1'b0;
        #1;
        check("miss_next_we", mem_we, 1);
        check("miss_next_addr", mem_addr, 32'h14);
        mem_ready = 1'b1;
        cycle();
`else
        // No forwarding: the load waits for both older writes, then reads memory.
        do_reset();
        drive(1, 0, 32'h5C, 32'd1);  cycle();
        drive(1, 0, 32'h60, 32'h55); cycle();
        drive(0, 1, 32'h60, 32'd0);
        mem_ready = 1'b1;
        w0 = wr_count;
        #1;
        check("drain_stall", cpu_stall, 1);
        n = 0;
        while (cpu_stall && n < 20) begin
            cycle();
            n++;
        end
        check("drain_timeout", (n < 20) ? 32'd0 : 32'd1, 32'd0);
        check("drain_writes_first", 32'(wr_count - w0), 2);
        check("drain_rd_we", mem_we, 0);
        check("drain_rdata", cpu_rdata, 32'h55);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
`endif

        // Reset while a write is in flight with three entries queued.
        do_reset();
        drive(1, 0, 32'h20, 32'd21); cycle();
        drive(1, 0, 32'h24, 32'd22); cycle();
        drive(1, 0, 32'h28, 32'd23); cycle();
        drive(1, 0, 32'h2C, 32'd24);
        #1;
        check("mid_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        check("mid_req_drop", mem_req, 0);
        check("mid_count", 32'(dut.u_fifo.count), 0);
        check("mid_stall", cpu_stall, 0);
        do_reset();
        mem_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) n++;
            cycle();
        end
        check("mid_no_write", n, 0);

        // Randomized traffic against the program-order model.
        do_reset();
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!last_stall) begin
                case ($urandom % 10)
                    0, 1, 2, 3: drive(1, 0, 32'(($urandom % 16) * 4 + ($urandom % 4)), $urandom);
                    4, 5, 6:    drive(0, 1, 32'(($urandom % 16) * 4 + ($urandom % 4)), 32'd0);
                    default:    drive(0, 0, 0, 0);
                endcase
            end
            mem_ready = ($urandom % 3) != 0;
            n = last_stall ? n + 1 : 0;
            if (n > 200) begin
                check("rand_stall_timeout", 32'(n), 0);
                break;
            end
            cycle();
        end
        drive(0, 0, 0, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || mem_req); i++) cycle();
        check("rand_drained", 32'(exp_q.size()), 0);
        check("rand_idle", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
